// File: rtl/msg_entry_writer_if.sv
// rtl/msg_entry_writer_if.sv - key/switch inputs and six-digit display bundle for the message writer
interface msg_entry_writer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [3:0]    char_in;
  logic          wr_n;
  logic          bs_n;
  logic          clr;
  logic [3:0]    a;
  logic [3:0]    b;
  logic [3:0]    c;
  logic [3:0]    d;
  logic [3:0]    e;
  logic [3:0]    f;
  logic [LW-1:0] len;
  logic          empty;
  logic          full;
  logic          ovf;

  modport master (
    output char_in, wr_n, bs_n, clr,
    input  a, b, c, d, e, f, len, empty, full, ovf
  );

  modport slave (
    input  char_in, wr_n, bs_n, clr,
    output a, b, c, d, e, f, len, empty, full, ovf
  );
endinterface

// File: rtl/msg_entry_writer.sv
// rtl/msg_entry_writer.sv - debounced write/backspace entry into a message buffer with six-digit window
module msg_entry_writer_deb #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s0_q, s1_q;
  logic          deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      s0_q       <= raw_n;
      s1_q       <= s0_q;
      deb_prev_q <= deb_q;
      // Level flips only after DEB_CYCLES consecutive disagreeing samples
      if (s1_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q <= s1_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = deb_prev_q & ~deb_q;
endmodule

module msg_entry_writer #(
  parameter int         DEPTH      = 16,
  parameter int         DEB_CYCLES = 500000,
  parameter logic [3:0] BLANK      = 4'hF
) (
  input logic               clk,
  input logic               rst_n,
  msg_entry_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          wr_ev, bs_ev;
  logic          clr_s0_q, clr_s1_q;
  logic [LW-1:0] len_q;
  logic          ovf_q;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    dig_q [6];
  logic [3:0]    dig_n [6];
  logic [LW-1:0] idx;
  logic          full_w, empty_w;
  logic          do_wr, do_bs;

  msg_entry_writer_deb #(.DEB_CYCLES(DEB_CYCLES)) u_wr_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (bus.wr_n),
    .press (wr_ev)
  );

  msg_entry_writer_deb #(.DEB_CYCLES(DEB_CYCLES)) u_bs_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (bus.bs_n),
    .press (bs_ev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_s0_q <= 1'b0;
      clr_s1_q <= 1'b0;
    end else begin
      clr_s0_q <= bus.clr;
      clr_s1_q <= clr_s0_q;
    end
  end

  assign full_w  = (len_q == LW'(DEPTH));
  assign empty_w = (len_q == '0);
  // Clear wins; coincident write and backspace cancel each other
  assign do_wr   = !clr_s1_q && wr_ev && !bs_ev;
  assign do_bs   = !clr_s1_q && bs_ev && !wr_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_s1_q) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (do_wr) begin
      if (full_w) ovf_q <= 1'b1;
      else        len_q <= len_q + 1'b1;
    end else if (do_bs && !empty_w) begin
      len_q <= len_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !full_w) mem_q[len_q[AW-1:0]] <= bus.char_in;
  end

  always_comb begin
    idx = '0;
    for (int k = 0; k < 6; k++) begin
      idx      = len_q - LW'(k + 1);
      dig_n[k] = (len_q > LW'(k)) ? mem_q[idx[AW-1:0]] : BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) dig_q[k] <= BLANK;
    end else begin
      for (int k = 0; k < 6; k++) dig_q[k] <= dig_n[k];
    end
  end

  assign bus.a     = dig_q[0];
  assign bus.b     = dig_q[1];
  assign bus.c     = dig_q[2];
  assign bus.d     = dig_q[3];
  assign bus.e     = dig_q[4];
  assign bus.f     = dig_q[5];
  assign bus.len   = len_q;
  assign bus.empty = empty_w;
  assign bus.full  = full_w;
  assign bus.ovf   = ovf_q;
endmodule
